// File: rtl/issue_buffer.sv
// In-order issue buffer: DEPTH-entry circular queue with flush, speculative squash and resolve.
// Define ISSUE_BUFFER_BYPASS_EN for zero-latency forwarding when the buffer is empty.
module issue_buffer #(
    parameter int unsigned PAYLOAD_WIDTH = 128,
    parameter int unsigned DEPTH         = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       kill_spec_i,
    input  logic                       resolve_spec_i,
    input  logic                       push_valid_i,
    input  logic                       push_speculative_i,
    input  logic [PAYLOAD_WIDTH-1:0]   push_payload_i,
    output logic                       push_ready_o,
    output logic                       pop_valid_o,
    output logic                       pop_speculative_o,
    output logic [PAYLOAD_WIDTH-1:0]   pop_payload_o,
    input  logic                       pop_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [PW-1:0]            r_wptr, r_rptr;
    logic [CW-1:0]            r_count;
    logic [DEPTH-1:0]         r_live, r_spec;
    logic [PAYLOAD_WIDTH-1:0] r_payload [DEPTH];

    logic [PW-1:0]    w_wptr_nxt, w_rptr_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic [DEPTH-1:0] w_live_nxt, w_spec_nxt;

    logic w_empty, w_full;
    logic w_head_valid, w_head_squashed;
    logic w_push_drop, w_push_fire, w_pop_fire;
    logic w_free, w_write, w_byp_take;

    assign w_empty         = (r_count == '0);
    assign w_full          = (r_count == CW'(DEPTH));
    assign w_head_valid    = !w_empty && r_live[r_rptr];
    assign w_head_squashed = !w_empty && !r_live[r_rptr];
    // A speculative packet arriving with a misprediction is already dead.
    assign w_push_drop     = kill_spec_i && push_speculative_i;
    assign w_push_fire     = push_valid_i && !w_full;
    assign w_pop_fire      = w_head_valid && pop_ready_i;
    assign w_free          = w_pop_fire || w_head_squashed;

`ifdef ISSUE_BUFFER_BYPASS_EN
    logic w_byp_on;
    assign w_byp_on   = w_empty && !flush_i;
    assign w_byp_take = w_byp_on && push_valid_i && !w_push_drop && pop_ready_i;
`else
    assign w_byp_take = 1'b0;
`endif

    assign w_write = w_push_fire && !w_push_drop && !w_byp_take && !flush_i;

    always_comb begin
        pop_valid_o       = w_head_valid;
        pop_speculative_o = w_head_valid && r_spec[r_rptr];
        pop_payload_o     = r_payload[r_rptr];
`ifdef ISSUE_BUFFER_BYPASS_EN
        if (w_byp_on) begin
            pop_valid_o       = push_valid_i && !w_push_drop;
            pop_speculative_o = push_speculative_i;
            pop_payload_o     = push_payload_i;
        end
`endif
    end

    assign push_ready_o = !w_full;
    assign count_o      = r_count;
    assign empty_o      = w_empty;
    assign full_o       = w_full;

    always_comb begin
        w_live_nxt  = r_live;
        w_spec_nxt  = r_spec;
        w_wptr_nxt  = r_wptr;
        w_rptr_nxt  = r_rptr;
        w_count_nxt = r_count;
        if (flush_i) begin
            w_live_nxt  = '0;
            w_spec_nxt  = '0;
            w_wptr_nxt  = '0;
            w_rptr_nxt  = '0;
            w_count_nxt = '0;
        end else begin
            if (kill_spec_i) begin
                w_live_nxt = r_live & ~r_spec;
            end
            // Kill leaves only non-speculative survivors, so clearing tags is correct for both.
            if (kill_spec_i || resolve_spec_i) begin
                w_spec_nxt = '0;
            end
            if (w_free) begin
                w_live_nxt[r_rptr] = 1'b0;
                w_spec_nxt[r_rptr] = 1'b0;
                w_rptr_nxt         = r_rptr + 1'b1;
            end
            if (w_write) begin
                w_live_nxt[r_wptr] = 1'b1;
                w_spec_nxt[r_wptr] = push_speculative_i;
                w_wptr_nxt         = r_wptr + 1'b1;
            end
            w_count_nxt = r_count + CW'(w_write) - CW'(w_free);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_live  <= '0;
            r_spec  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_live  <= w_live_nxt;
            r_spec  <= w_spec_nxt;
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_payload[i] <= '0;
            end
        end else if (w_write) begin
            r_payload[r_wptr] <= push_payload_i;
        end
    end

endmodule
